// File: rtl/mux_channel_scanner_pkg.sv
// Shared constants and state encoding for the mux channel scanner.
// Channel count is fixed to match the team's 4:1 mux.
package mux_channel_scanner_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

endpackage

// File: rtl/mux_channel_scanner_finder.sv
// Combinational channel walker: lowest enabled channel,
// next higher enabled channel and a last-channel flag.
module next_channel_finder
    import mux_channel_scanner_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  lowest,
    output logic [SEL_W-1:0]  nxt,
    output logic              is_last
);

    // Descending scans leave the lowest qualifying index
    always_comb begin
        lowest  = '0;
        nxt     = cur;
        is_last = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest = SEL_W'(i);
            end
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                nxt     = SEL_W'(i);
                is_last = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_channel_scanner.sv
// Sequencer driving the 4:1 mux select and capturing y per channel,
// publishing a 4-bit snapshot with a one-cycle valid pulse.
module mux_channel_scanner
    import mux_channel_scanner_pkg::*;
#(
    parameter int DWELL_W = 4,
    parameter int NUM_CH_P = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               mode,
    input  logic [3:0]         ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               y_in,
    output logic [1:0]         s,
    output logic [3:0]         sample,
    output logic               valid,
    output logic               busy
);

    state_t             state, state_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [DWELL_W-1:0] d_q, d_n;
    logic [3:0]         mask_q, mask_n;
    logic               mode_q, mode_n;
    logic [3:0]         shadow, shadow_n;
    logic [1:0]         s_n;
    logic [3:0]         sample_n;
    logic               valid_n, busy_n;

    logic [1:0]         lo_req, lo_q, nxt_q;
    logic               last_q;
    logic               unused_last;
    logic [1:0]         unused_nxt;
    logic [DWELL_W-1:0] dwell_eff;

    // Lowest channel of the requested mask, used at scan start
    next_channel_finder u_req (
        .mask    (ch_mask),
        .cur     (2'd0),
        .lowest  (lo_req),
        .nxt     (unused_nxt),
        .is_last (unused_last)
    );

    // Walker over the latched mask for the scan in progress
    next_channel_finder u_scan (
        .mask    (mask_q),
        .cur     (s),
        .lowest  (lo_q),
        .nxt     (nxt_q),
        .is_last (last_q)
    );

    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            s      <= '0;
            cnt    <= '0;
            d_q    <= DWELL_W'(1);
            mask_q <= '0;
            mode_q <= 1'b0;
            shadow <= '0;
            sample <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            s      <= s_n;
            cnt    <= cnt_n;
            d_q    <= d_n;
            mask_q <= mask_n;
            mode_q <= mode_n;
            shadow <= shadow_n;
            sample <= sample_n;
            valid  <= valid_n;
            busy   <= busy_n;
        end
    end

    // Next-state and next-output logic; abort always wins
    always_comb begin
        state_n  = state;
        s_n      = s;
        cnt_n    = cnt;
        d_n      = d_q;
        mask_n   = mask_q;
        mode_n   = mode_q;
        shadow_n = shadow;
        sample_n = sample;
        valid_n  = 1'b0;
        busy_n   = busy;
        unique case (state)
            ST_IDLE: begin
                busy_n = 1'b0;
                if (start && !abort && (ch_mask != '0)) begin
                    mask_n   = ch_mask;
                    mode_n   = mode;
                    d_n      = dwell_eff;
                    shadow_n = '0;
                    s_n      = lo_req;
                    cnt_n    = dwell_eff - 1'b1;
                    busy_n   = 1'b1;
                    state_n  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    shadow_n[s] = y_in;
                    if (!last_q) begin
                        s_n   = nxt_q;
                        cnt_n = d_q - 1'b1;
                    end else begin
                        sample_n = shadow_n & mask_q;
                        valid_n  = 1'b1;
                        if (mode_q) begin
                            s_n      = lo_q;
                            cnt_n    = d_q - 1'b1;
                            shadow_n = '0;
                        end else begin
                            state_n = ST_IDLE;
                            busy_n  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Directed bench for mux_channel_scanner with a behavioural 4:1 mux.
// Table vectors for single scans plus hand sequences for corner cases.
module tb_mux_channel_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, mode;
    logic [3:0] ch_mask;
    logic [3:0] dwell;
    logic       y_in;
    logic [1:0] s;
    logic [3:0] sample;
    logic       valid, busy;
    logic [3:0] pat;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] dw;
        logic [3:0] p;
        int         mid;
        logic [3:0] exp_sample;
        int         exp_lat;
    } vec_t;

    vec_t vecs[6];

    mux_channel_scanner #(.DWELL_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .mode    (mode),
        .ch_mask (ch_mask),
        .dwell   (dwell),
        .y_in    (y_in),
        .s       (s),
        .sample  (sample),
        .valid   (valid),
        .busy    (busy)
    );

    assign y_in = pat[s];

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(vec_t v);
        int d;
        int e;
        int lst[4];
        bit seen;
        d = (v.dw == 0) ? 1 : int'(v.dw);
        e = 0;
        for (int c = 0; c < 4; c++) begin
            if (v.mask[c]) begin
                lst[e] = c;
                e++;
            end
        end
        ch_mask = v.mask;
        dwell = v.dw;
        pat = v.p;
        mode = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("first_s", int'(s), lst[0]);
        chk("busy_on", int'(busy), 1);
        seen = 1'b0;
        for (int n = 1; n < 80 && !seen; n++) begin
            start = (n == v.mid);
            step();
            start = 1'b0;
            if (valid) begin
                seen = 1'b1;
                chk("latency", n, v.exp_lat);
                chk("sample", int'(sample), int'(v.exp_sample));
                chk("busy_off", int'(busy), 0);
                step();
                chk("valid_pulse", int'(valid), 0);
            end else if (n < e * d) begin
                if (s !== 2'(lst[n / d])) begin
                    chk("s_seq", int'(s), lst[n / d]);
                end
            end
        end
        if (!seen) begin
            chk("timeout", 0, 1);
        end
    endtask

    task automatic run_abort(int at, logic [3:0] prev);
        ch_mask = 4'b1111;
        dwell = 4'd1;
        mode = 1'b0;
        pat = 4'b0110;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n < at; n++) begin
            step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(valid), 0);
        chk("abort_sample", int'(sample), int'(prev));
        for (int n = 0; n < 4; n++) begin
            step();
            if (valid) begin
                chk("abort_late_valid", 1, 0);
            end
        end
    endtask

    initial begin
        vecs[0] = '{4'b1111, 4'd2, 4'b1101, 0, 4'b1101, 8};
        vecs[1] = '{4'b1010, 4'd0, 4'b1101, 0, 4'b1000, 2};
        vecs[2] = '{4'b0100, 4'd5, 4'b0100, 0, 4'b0100, 5};
        vecs[3] = '{4'b1001, 4'd1, 4'b1111, 0, 4'b1001, 2};
        vecs[4] = '{4'b0110, 4'd3, 4'b0010, 0, 4'b0010, 6};
        vecs[5] = '{4'b1111, 4'd2, 4'b0101, 3, 4'b0101, 8};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mode = 1'b0;
        ch_mask = 4'b0;
        dwell = 4'd0;
        pat = 4'b0;
        #12;
        chk("rst_s", int'(s), 0);
        chk("rst_sample", int'(sample), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            step();
        end

        // Continuous scan of channel 0, y toggled between scans
        ch_mask = 4'b0001;
        dwell = 4'd3;
        mode = 1'b1;
        pat = 4'b0001;
        start = 1'b1;
        step();
        start = 1'b0;
        ch_mask = 4'b1111;
        mode = 1'b0;
        dwell = 4'd1;
        for (int n = 1; n <= 9; n++) begin
            step();
            chk("cont_valid", int'(valid), (n % 3 == 0) ? 1 : 0);
            if (s !== 2'd0) begin
                chk("cont_s", int'(s), 0);
            end
            if (busy !== 1'b1) begin
                chk("cont_busy", int'(busy), 1);
            end
            if (n % 3 == 0) begin
                chk("cont_sample", int'(sample), int'({3'b0, pat[0]}));
                pat = ~pat;
            end
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("cont_abort_busy", int'(busy), 0);
        chk("cont_abort_valid", int'(valid), 0);
        step();

        // Establish a known snapshot, then abort before / at final capture
        run_vec(vecs[0]);
        step();
        run_abort(3, 4'b1101);
        run_abort(4, 4'b1101);

        // Empty mask and start+abort in idle are ignored
        ch_mask = 4'b0000;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("zero_mask_busy", int'(busy), 0);
        step();
        chk("zero_mask_valid", int'(valid), 0);
        ch_mask = 4'b1111;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", int'(busy), 0);
        step();
        chk("start_abort_valid", int'(valid), 0);

        // Asynchronous reset between edges in the middle of a scan
        ch_mask = 4'b1111;
        dwell = 4'd2;
        pat = 4'b1111;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_s", int'(s), 0);
        chk("arst_sample", int'(sample), 0);
        chk("arst_valid", int'(valid), 0);
        chk("arst_busy", int'(busy), 0);
        #3;
        rst_n = 1'b1;
        step();
        run_vec(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
